// File: rtl/mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// mul_share_ctrl : round-robin sharing of one sequential 64x64 multiplier
// Revision: 1.0
// ============================================================================
module mul_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 80,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*64-1:0]   req_multiplier,
  input  logic [NUM_REQ*64-1:0]   req_multiplicand,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [127:0]            rsp_result,
  output logic                    rsp_error,
  output logic [63:0]             mul_multiplier,
  output logic [63:0]             mul_multiplicand,
  output logic                    mul_op_start,
  output logic                    mul_op_clear,
  input  logic                    mul_op_done,
  input  logic [127:0]            mul_result,
  output logic                    busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLEAR, S_RESP} state_t;

  state_t              r_state, w_next;
  logic [ID_W-1:0]     r_ptr, r_id;
  logic [63:0]         r_a, r_b;
  logic [CNT_W-1:0]    r_cnt;
  logic [127:0]        r_result;
  logic                r_error;

  logic [NUM_REQ-1:0]  w_rot, w_grant;
  logic [ID_W-1:0]     w_off, w_win, w_ptr_nxt;
  logic [ID_W:0]       w_sum;
  logic                w_found, w_accept, w_timeout;

  // Rotate requests so the pointer position lands at bit 0; lowest set bit wins.
  always_comb begin
    w_rot   = NUM_REQ'({req_valid, req_valid} >> r_ptr);
    w_found = 1'b0;
    w_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = ID_W'(k);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (ID_W+1)'(NUM_REQ))
      w_sum = w_sum - (ID_W+1)'(NUM_REQ);
    w_win = w_sum[ID_W-1:0];
  end

  assign w_ptr_nxt = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
  assign w_grant   = (r_state == S_IDLE && w_found && !reset) ? (NUM_REQ'(1) << w_win) : '0;
  assign w_accept  = |(req_valid & w_grant);
  assign w_timeout = (r_cnt == c_cnt_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (mul_op_done || w_timeout) w_next = S_CLEAR;
      S_CLEAR: w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_id     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_error  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_a   <= req_multiplier[64*w_win +: 64];
        r_b   <= req_multiplicand[64*w_win +: 64];
        r_id  <= w_win;
        r_ptr <= w_ptr_nxt;
        r_cnt <= '0;
      end
      // A done seen on the last allowed cycle still counts as success.
      if (r_state == S_RUN) begin
        if (mul_op_done) begin
          r_result <= mul_result;
          r_error  <= 1'b0;
        end else if (w_timeout) begin
          r_result <= '0;
          r_error  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign req_ready        = w_grant;
  assign rsp_valid        = (r_state == S_RESP);
  assign rsp_id           = r_id;
  assign rsp_result       = r_result;
  assign rsp_error        = r_error;
  assign mul_multiplier   = r_a;
  assign mul_multiplicand = r_b;
  assign mul_op_start     = (r_state == S_RUN);
  assign mul_op_clear     = (r_state == S_CLEAR);
  assign busy             = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mul_share_ctrl : directed + randomized bench with a transaction-level model
// Revision: 1.0
// ============================================================================
module tb_mul_share_ctrl;

  localparam int N  = 4;
  localparam int TO = 80;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req_valid, req_ready;
  logic [N*64-1:0]      req_multiplier, req_multiplicand;
  logic                 rsp_valid, rsp_ready, rsp_error;
  logic [IW-1:0]        rsp_id;
  logic [127:0]         rsp_result;
  logic [63:0]          mul_multiplier, mul_multiplicand;
  logic                 mul_op_start, mul_op_clear, mul_op_done;
  logic [127:0]         mul_result;
  logic                 busy;

  int total = 0;
  int bad   = 0;

  mul_share_ctrl #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_multiplier(req_multiplier), .req_multiplicand(req_multiplicand),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_error(rsp_error),
    .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_op_start(mul_op_start), .mul_op_clear(mul_op_clear),
    .mul_op_done(mul_op_done), .mul_result(mul_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic expired(input string nm);
    total++;
    bad++;
    $display("FAIL %s bound expired", nm);
  endtask

  // Multiplier stand-in: done rises mul_lat start-cycles after start; 0 = never.
  int           mul_lat;
  int           mm_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mm_cnt      <= 0;
      mul_op_done <= 1'b0;
      mul_result  <= '0;
    end else if (mul_op_clear) begin
      mm_cnt      <= 0;
      mul_op_done <= 1'b0;
    end else if (mul_op_start && !mul_op_done) begin
      if (mul_lat != 0 && mm_cnt + 1 >= mul_lat) begin
        mul_op_done <= 1'b1;
        mul_result  <= 128'(mul_multiplier) * 128'(mul_multiplicand);
      end
      mm_cnt <= mm_cnt + 1;
    end
  end

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Transaction model: phase 0 waiting, 1 multiplying, 2 clearing, 3 responding.
  int           m_phase, m_ptr, m_id, m_run, m_w;
  logic [63:0]  m_a, m_b;
  logic         m_err;
  logic [N-1:0] m_ready;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_req_ready", 128'(req_ready), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("rst_start", 128'(mul_op_start), 128'(0));
      chk("rst_clear", 128'(mul_op_clear), 128'(0));
      chk("rst_result", rsp_result, 128'(0));
      chk("rst_error", 128'(rsp_error), 128'(0));
      chk("rst_id", 128'(rsp_id), 128'(0));
      chk("rst_opA", 128'(mul_multiplier), 128'(0));
      m_phase = 0; m_ptr = 0; m_id = 0; m_run = 0; m_a = '0; m_b = '0; m_err = 1'b0;
    end else begin
      m_w     = rr_pick(req_valid, m_ptr);
      m_ready = (m_phase == 0 && m_w >= 0) ? (N'(1) << m_w) : '0;
      chk("req_ready", 128'(req_ready), 128'(m_ready));
      chk("busy", 128'(busy), 128'(m_phase != 0));
      chk("op_start", 128'(mul_op_start), 128'(m_phase == 1));
      chk("op_clear", 128'(mul_op_clear), 128'(m_phase == 2));
      chk("rsp_valid", 128'(rsp_valid), 128'(m_phase == 3));
      if (m_phase != 0) begin
        chk("opA", 128'(mul_multiplier), 128'(m_a));
        chk("opB", 128'(mul_multiplicand), 128'(m_b));
      end
      if (m_phase == 3) begin
        chk("rsp_id", 128'(rsp_id), 128'(m_id));
        chk("rsp_error", 128'(rsp_error), 128'(m_err));
        chk("rsp_result", rsp_result, m_err ? 128'(0) : 128'(m_a) * 128'(m_b));
      end
      case (m_phase)
        0: if (m_w >= 0) begin
             m_a = req_multiplier[64*m_w +: 64];
             m_b = req_multiplicand[64*m_w +: 64];
             m_id = m_w; m_ptr = (m_w + 1) % N; m_run = 0; m_phase = 1;
           end
        1: begin
             m_run++;
             if (mul_op_done) begin m_err = 1'b0; m_phase = 2; end
             else if (m_run == TO) begin m_err = 1'b1; m_phase = 2; end
           end
        2: m_phase = 3;
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One transaction: wait for grant, count start/clear cycles, hold the response.
  task automatic run_one(input logic [N-1:0] v, input int lat, input int hold,
                         input logic [N-1:0] bg, output int gid, output logic [127:0] res,
                         output logic err, output int nstart, output int nclear);
    bit got;
    gid = -1; res = '0; err = 1'b0; nstart = 0; nclear = 0;
    req_valid = v; mul_lat = lat;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) if (req_valid[k] && req_ready[k]) begin gid = k; got = 1; end
    end
    if (!got) begin expired("grant_wait"); req_valid = '0; return; end
    tick(); req_valid = '0;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
      else begin
        if (mul_op_start) nstart++;
        if (mul_op_clear) nclear++;
      end
    end
    if (!got) begin expired("rsp_wait"); return; end
    res = rsp_result; err = rsp_error;
    tick(); req_valid = bg;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 128'(rsp_valid), 128'(1));
      chk("hold_req_ready", 128'(req_ready), 128'(0));
      tick();
    end
    rsp_ready = 1'b1; req_valid = '0;
    tick(); rsp_ready = 1'b0;
  endtask

  int           gid, ns, nc, ng, r;
  logic [127:0] res;
  logic         err;
  int           grants[5];

  initial begin
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0; mul_lat = 64;
    req_multiplier = '0; req_multiplicand = '0;
    repeat (3) tick();
    req_valid = 4'b1111; #1;
    chk("reset_ready_gated", 128'(req_ready), 128'(0));
    req_valid = '0;
    tick(); reset = 1'b0;

    // Single request, 3*5 after 64 multiplier cycles.
    req_multiplier[63:0] = 64'd3; req_multiplicand[63:0] = 64'd5;
    run_one(4'b0001, 64, 0, 4'b0000, gid, res, err, ns, nc);
    chk("t1_id", 128'(gid), 128'(0));
    chk("t1_result", res, 128'd15);
    chk("t1_error", 128'(err), 128'(0));
    chk("t1_run_cycles", 128'(ns), 128'(65));
    chk("t1_clear_pulses", 128'(nc), 128'(1));

    // Full-scale operands.
    req_multiplier[127:64] = '1; req_multiplicand[127:64] = '1;
    run_one(4'b0010, 20, 0, 4'b0000, gid, res, err, ns, nc);
    chk("t3_id", 128'(gid), 128'(1));
    chk("t3_result", res, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

    // Multiplier never answers.
    req_multiplier[191:128] = 64'd7; req_multiplicand[191:128] = 64'd9;
    run_one(4'b0100, 0, 0, 4'b0000, gid, res, err, ns, nc);
    chk("t4_id", 128'(gid), 128'(2));
    chk("t4_error", 128'(err), 128'(1));
    chk("t4_result", res, 128'(0));
    chk("t4_run_cycles", 128'(ns), 128'(TO));
    chk("t4_clear_pulses", 128'(nc), 128'(1));

    // Done on the final allowed cycle wins over timeout.
    req_multiplier[255:192] = 64'd11; req_multiplicand[255:192] = 64'd13;
    run_one(4'b1000, TO - 1, 10, 4'b0111, gid, res, err, ns, nc);
    chk("t5_id", 128'(gid), 128'(3));
    chk("t5_error", 128'(err), 128'(0));
    chk("t5_result", res, 128'd143);
    chk("t5_run_cycles", 128'(ns), 128'(TO));

    // Async reset mid-RUN, then round-robin order from requester 0.
    req_valid = 4'b1111; mul_lat = 64;
    ns = 0;
    for (int i = 0; i < 20 && !mul_op_start; i++) begin @(negedge clk); ns = i + 1; end
    if (!mul_op_start) expired("t6_start_wait");
    repeat (5) tick();
    #2 reset = 1'b1; #1;
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_start", 128'(mul_op_start), 128'(0));
    chk("t6_req_ready", 128'(req_ready), 128'(0));
    chk("t6_opA", 128'(mul_multiplier), 128'(0));
    tick(); reset = 1'b0; rsp_ready = 1'b1; mul_lat = 3;
    ng = 0;
    for (int i = 0; i < 500 && ng < 5; i++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) if (req_valid[k] && req_ready[k] && ng < 5) begin grants[ng] = k; ng++; end
    end
    if (ng < 5) expired("t2_grants");
    for (int i = 0; i < ng; i++) chk("t2_grant_order", 128'(grants[i]), 128'((i % 4)));
    tick(); req_valid = '0;
    for (int i = 0; i < 200 && busy; i++) tick();
    rsp_ready = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 2500; c++) begin
      tick();
      req_valid = N'($urandom);
      for (int k = 0; k < N; k++) begin
        req_multiplier[64*k +: 64]   = {$urandom, $urandom};
        req_multiplicand[64*k +: 64] = {$urandom, $urandom};
      end
      rsp_ready = ($urandom % 3) != 0;
      if (!mul_op_start) begin
        r = $urandom % 10;
        mul_lat = (r == 0) ? 0 : (r == 1) ? TO - 1 : (r == 2) ? TO : 1 + int'($urandom % 40);
      end
    end
    tick(); req_valid = '0; rsp_ready = 1'b1;
    ng = 0;
    for (int i = 0; i < 300 && busy; i++) begin tick(); ng = i; end
    if (busy) expired("drain");
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
